// File: rtl/fft_frame_ctrl.sv
// Audio-to-FFT frame controller: buffers samples into framed Avalon-ST beats and checks result framing.
// Optional macro FFT_FRAME_CONTINUOUS_EN: stream frames back-to-back without waiting for results.
module fft_frame_ctrl #(
    parameter int FRAME_LEN = 1024,
    parameter int DW        = 16
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_start,
    input  logic          i_clear,
    input  logic          i_sample_valid,
    input  logic [DW-1:0] i_sample,
    output logic          o_sample_ready,
    input  logic          i_source_ready,
    output logic          o_source_valid,
    output logic [DW-1:0] o_source_data,
    output logic          o_source_sop,
    output logic          o_source_eop,
    input  logic          i_sink_valid,
    input  logic          i_sink_sop,
    input  logic          i_sink_eop,
    output logic          o_busy,
    output logic          o_result_done,
    output logic          o_error,
    output logic [15:0]   o_frame_cnt
);
    localparam int AW = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_RESULT} state_t;
    state_t state, state_nxt;

    logic          full;
    logic [DW-1:0] hold;
    logic [AW-1:0] beat_cnt;
    logic [AW-1:0] res_cnt;
    logic [AW-1:0] res_idx;
    logic          res_open;
    logic          res_bad;
    logic          res_fault;
    logic          xfer;
    logic          eop_xfer;
    logic          accept;

    assign o_source_valid = full && (state == STREAM);
    assign xfer           = o_source_valid && i_source_ready;
    assign eop_xfer       = xfer && (beat_cnt == LAST);
    // Outside STREAM samples are swallowed so the audio source never stalls.
    assign o_sample_ready = (state != STREAM) || !full || xfer;
    assign accept         = (state == STREAM) && i_sample_valid && o_sample_ready;
    assign o_source_data  = hold;
    assign o_source_sop   = o_source_valid && (beat_cnt == '0);
    assign o_source_eop   = o_source_valid && (beat_cnt == LAST);
    assign o_busy         = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (i_start) state_nxt = STREAM;
            STREAM: begin
                if (eop_xfer) begin
`ifdef FFT_FRAME_CONTINUOUS_EN
                    state_nxt = STREAM;
`else
                    state_nxt = WAIT_RESULT;
`endif
                end
            end
            WAIT_RESULT: if (i_sink_valid && i_sink_eop) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // A sample caught on the cycle that leaves STREAM belongs to no frame; drop it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            full <= 1'b0;
            hold <= '0;
        end else if (state_nxt != STREAM) begin
            full <= 1'b0;
        end else if (accept) begin
            full <= 1'b1;
            hold <= i_sample;
        end else if (xfer) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)                                beat_cnt <= '0;
        else if (state == IDLE && state_nxt == STREAM) beat_cnt <= '0;
        else if (xfer)                                 beat_cnt <= beat_cnt + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)    o_frame_cnt <= '0;
        else if (i_clear)  o_frame_cnt <= '0;
        else if (eop_xfer) o_frame_cnt <= o_frame_cnt + 16'd1;
    end

    // Result framing: res_idx is the index of the current sink beat within its frame.
    always_comb begin
        res_idx   = i_sink_sop ? '0 : res_cnt + 1'b1;
        res_fault = 1'b0;
        if (i_sink_valid) begin
            if (state == IDLE)                       res_fault = 1'b1;
            if (i_sink_sop && res_open)              res_fault = 1'b1;
            if (i_sink_eop && (res_idx != LAST || !(res_open || i_sink_sop)))
                res_fault = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            res_cnt  <= '0;
            res_open <= 1'b0;
            res_bad  <= 1'b0;
        end else if (i_sink_valid) begin
            if (i_sink_sop || res_open) res_cnt <= res_idx;
            if (i_sink_eop)                    res_open <= 1'b0;
            else if (i_sink_sop || res_open)   res_open <= 1'b1;
            if (i_sink_sop) res_bad <= res_fault;
            else            res_bad <= res_bad | res_fault;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_result_done <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            o_result_done <= i_sink_valid && i_sink_eop && !res_fault && (i_sink_sop || !res_bad);
            if (i_clear)                        o_error <= 1'b0;
            else if (i_sink_valid && res_fault) o_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl at FRAME_LEN=16; continuous-mode sequence when FFT_FRAME_CONTINUOUS_EN is defined.
module tb_fft_frame_ctrl;
    localparam int FL = 16;
    localparam int DW = 16;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_start, i_clear, i_sample_valid, i_source_ready;
    logic [DW-1:0] i_sample;
    logic          i_sink_valid, i_sink_sop, i_sink_eop;
    logic          o_sample_ready, o_source_valid, o_source_sop, o_source_eop;
    logic [DW-1:0] o_source_data;
    logic          o_busy, o_result_done, o_error;
    logic [15:0]   o_frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    fft_frame_ctrl #(.FRAME_LEN(FL), .DW(DW)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_clear(i_clear),
        .i_sample_valid(i_sample_valid), .i_sample(i_sample), .o_sample_ready(o_sample_ready),
        .i_source_ready(i_source_ready), .o_source_valid(o_source_valid),
        .o_source_data(o_source_data), .o_source_sop(o_source_sop), .o_source_eop(o_source_eop),
        .i_sink_valid(i_sink_valid), .i_sink_sop(i_sink_sop), .i_sink_eop(i_sink_eop),
        .o_busy(o_busy), .o_result_done(o_result_done), .o_error(o_error),
        .o_frame_cnt(o_frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"}, o_source_valid, 0);
        chk({tag, "_sop"},   o_source_sop, 0);
        chk({tag, "_eop"},   o_source_eop, 0);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_done"},  o_result_done, 0);
        chk({tag, "_err"},   o_error, 0);
        chk({tag, "_rdy"},   o_sample_ready, 1);
        chk({tag, "_fcnt"},  o_frame_cnt, 0);
    endtask

    task automatic start_frame();
        @(negedge i_clk) i_start = 1'b1;
        @(negedge i_clk) i_start = 1'b0;
    endtask

    // Feeds a sample every cycle; checks every transfer in order and stall stability.
    task automatic stream(input int base, input bit toggle, input int stop_at);
        int nxt = 0, beats = 0, cyc = 0;
        bit stalled = 1'b0;
        logic [DW-1:0] hd;
        logic hs, he;
        while (beats < stop_at && cyc < 500) begin
            @(negedge i_clk);
            i_sample_valid = 1'b1;
            i_sample       = DW'(base + nxt);
            i_source_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (stalled) begin
                chk("stall_valid", o_source_valid, 1);
                chk("stall_data",  o_source_data, hd);
                chk("stall_sop",   o_source_sop, hs);
                chk("stall_eop",   o_source_eop, he);
            end
            if (o_source_valid && i_source_ready) begin
                chk("beat_data", o_source_data, DW'(base + beats));
                chk("beat_sop",  o_source_sop, (beats % FL) == 0);
                chk("beat_eop",  o_source_eop, (beats % FL) == FL - 1);
                beats++;
                stalled = 1'b0;
            end else if (o_source_valid) begin
                stalled = 1'b1;
                hd = o_source_data; hs = o_source_sop; he = o_source_eop;
            end else begin
                stalled = 1'b0;
            end
            if (o_sample_ready) nxt++;
            cyc++;
        end
        if (beats < stop_at) chk("stream_timeout", beats, stop_at);
    endtask

    task automatic idle_inputs();
        i_sample_valid = 1'b0;
        i_source_ready = 1'b0;
        i_sink_valid   = 1'b0;
        i_sink_sop     = 1'b0;
        i_sink_eop     = 1'b0;
        i_start        = 1'b0;
        i_clear        = 1'b0;
    endtask

    task automatic send_result(input int eop_at, input int exp_done);
        int pulses = 0;
        for (int b = 0; b <= eop_at; b++) begin
            @(negedge i_clk);
            i_sink_valid = 1'b1;
            i_sink_sop   = (b == 0);
            i_sink_eop   = (b == eop_at);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            i_sink_valid = 1'b0; i_sink_sop = 1'b0; i_sink_eop = 1'b0;
            #1;
            if (c == 0) chk("res_busy_after", o_busy, 0);
            if (o_result_done) pulses++;
        end
        chk("res_done_pulses", pulses, exp_done);
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_sample  = '0;
        idle_inputs();
        #3;
        chk_reset_outs("rst");
        @(negedge i_clk) i_reset_n = 1'b1;

`ifdef FFT_FRAME_CONTINUOUS_EN
        start_frame();
        stream(1000, 1'b0, 3 * FL);
        @(negedge i_clk) idle_inputs();
        #1;
        chk("cont_fcnt", o_frame_cnt, 3);
        chk("cont_busy", o_busy, 1);
        start_frame();
        #1 chk("cont_start_ignored_fcnt", o_frame_cnt, 3);
`else
        // Basic frame, ready always high
        start_frame();
        #1 chk("t1_busy", o_busy, 1);
        stream(100, 1'b0, FL);
        @(negedge i_clk);
        i_source_ready = 1'b1;
        #1;
        chk("t1_fcnt", o_frame_cnt, 1);
        chk("t1_wait_busy", o_busy, 1);
        chk("t1_wait_valid", o_source_valid, 0);
        chk("t1_wait_rdy", o_sample_ready, 1);
        @(negedge i_clk) #1 chk("t1_wait_discard", o_source_valid, 0);
        idle_inputs();
        start_frame();
        send_result(FL - 1, 1);
        chk("t2_err", o_error, 0);
        chk("t2_fcnt", o_frame_cnt, 1);

        // Ready toggling every cycle
        start_frame();
        stream(200, 1'b1, FL);
        @(negedge i_clk) idle_inputs();
        #1 chk("t3_fcnt", o_frame_cnt, 2);
        send_result(FL - 1, 1);

        // Short result frame sets a sticky error
        start_frame();
        stream(300, 1'b0, FL);
        @(negedge i_clk) idle_inputs();
        send_result(9, 0);
        chk("t4_err", o_error, 1);
        repeat (4) @(negedge i_clk);
        #1 chk("t4_err_sticky", o_error, 1);
        chk("t4_fcnt", o_frame_cnt, 3);
        @(negedge i_clk) i_clear = 1'b1;
        @(negedge i_clk) i_clear = 1'b0;
        #1;
        chk("t4_clr_err", o_error, 0);
        chk("t4_clr_fcnt", o_frame_cnt, 0);
        @(negedge i_clk) i_sink_valid = 1'b1;
        @(negedge i_clk) i_sink_valid = 1'b0;
        #1 chk("t4_idle_sink_err", o_error, 1);
        @(negedge i_clk) i_clear = 1'b1;
        @(negedge i_clk) i_clear = 1'b0;
        #1 chk("t4_clr2_err", o_error, 0);

        // Reset in the middle of a frame, then a fresh frame
        start_frame();
        stream(400, 1'b0, 7);
        @(negedge i_clk);
        i_reset_n = 1'b0;
        #1;
        chk_reset_outs("t5_rst");
        idle_inputs();
        @(negedge i_clk) i_reset_n = 1'b1;
        start_frame();
        stream(500, 1'b0, FL);
        @(negedge i_clk) idle_inputs();
        #1 chk("t5_fcnt", o_frame_cnt, 1);
        send_result(FL - 1, 1);
        chk("t5_err", o_error, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
